i2s_tx: RTL and testbench

Serial audio output stage sitting directly downstream of the symmetric FIR filter. Takes the filter's 24-bit signed output for left and right channels and transmits it to the audio codec DAC as a standard I2S master stream. Generates BCLK and LRCLK from the system clock and issues a per-frame strobe so upstream stages can advance exactly one sample per frame.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/i2s_clkgen.sv | 58 +++++
 rtl/i2s_tx.sv | 94 +++++++++
 tb/tb_i2s_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio datapath definitions.
// Used by the FIR chain and the I2S output stage so sample width and slot
// geometry are defined in one place.
package audio_pkg;

    // Sample width carried through the filter chain.
    localparam int SAMPLE_W     = 24;
    // BCLK periods per I2S channel slot.
    localparam int I2S_SLOT     = 32;
    // Default system clocks per BCLK period.
    localparam int I2S_BCLK_DIV = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S clock generator.
// Divides clk into BCLK, counts bit positions across a stereo frame and
// produces LRCLK together with the falling-BCLK and frame-latch strobes that
// the data path uses to advance.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter  int SLOT     = I2S_SLOT,
    parameter  int BCLK_DIV = I2S_BCLK_DIV,
    localparam int BW       = cnt_w(2 * SLOT)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          fall_en,
    output logic          frame_latch,
    output logic [BW-1:0] bit_nxt,
    output logic          bclk,
    output logic          lrclk
);

    localparam int DW = cnt_w(BCLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] SLOT_C   = BW'(SLOT);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [BW-1:0] bit_cnt;

    // Next-count decode; fall_en marks the edge on which BCLK falls.
    always_comb begin
        fall_en     = (div_cnt == DIV_LAST);
        div_nxt     = fall_en ? '0 : div_cnt + 1'b1;
        bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        frame_latch = fall_en && (bit_cnt == BIT_LAST);
    end

    // Counters and registered clocks; BCLK/LRCLK follow the counter values
    // they will hold after this edge, so they line up with div_cnt/bit_cnt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bclk    <= (div_nxt >= DIV_HALF);
            if (fall_en) begin
                bit_cnt <= bit_nxt;
                lrclk   <= (bit_nxt >= SLOT_C);
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter.
// Latches one stereo sample pair per frame (optionally muted to zero) and
// shifts it out MSB first with the standard one-BCLK delay after LRCLK
// changes. frame_strobe tells upstream that left_in/right_in/mute are
// captured on the next rising clk edge; upstream advances on that same edge.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int WIDTH    = SAMPLE_W,
    parameter int SLOT     = I2S_SLOT,
    parameter int BCLK_DIV = I2S_BCLK_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] left_in,
    input  logic signed [WIDTH-1:0] right_in,
    input  logic                    mute,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    frame_strobe
);

    localparam int BW = cnt_w(2 * SLOT);

    localparam logic [BW-1:0] SLOT_C  = BW'(SLOT);
    localparam logic [BW-1:0] WIDTH_C = BW'(WIDTH);

    logic          fall_en;
    logic          frame_latch;
    logic [BW-1:0] bit_nxt;

    logic [WIDTH-1:0] left_sr;
    logic [WIDTH-1:0] right_sr;

    logic [BW-1:0]    pos_nxt;
    logic             right_nxt;
    logic             data_nxt;
    logic [WIDTH-1:0] left_load;
    logic [WIDTH-1:0] right_load;

    i2s_clkgen #(
        .SLOT     (SLOT),
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .fall_en     (fall_en),
        .frame_latch (frame_latch),
        .bit_nxt     (bit_nxt),
        .bclk        (bclk),
        .lrclk       (lrclk)
    );

    // Slot position of the upcoming bit, and mute gating of the latch data.
    always_comb begin
        right_nxt  = (bit_nxt >= SLOT_C);
        pos_nxt    = right_nxt ? (bit_nxt - SLOT_C) : bit_nxt;
        data_nxt   = (pos_nxt != '0) && (pos_nxt <= WIDTH_C);
        left_load  = mute ? '0 : left_in;
        right_load = mute ? '0 : right_in;
    end

    // Upstream handshake: strobe is high in the last clk of the frame.
    always_comb begin
        frame_strobe = frame_latch;
    end

    // Shift registers and registered serial data; sdata only moves on
    // falling BCLK. Position 0 of each slot is the I2S delay bit and
    // positions past WIDTH pad with zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            left_sr  <= '0;
            right_sr <= '0;
            sdata    <= 1'b0;
        end else if (frame_latch) begin
            left_sr  <= left_load;
            right_sr <= right_load;
            sdata    <= 1'b0;
        end else if (fall_en) begin
            if (!data_nxt) begin
                sdata <= 1'b0;
            end else if (right_nxt) begin
                sdata    <= right_sr[WIDTH-1];
                right_sr <= right_sr << 1;
            end else begin
                sdata   <= left_sr[WIDTH-1];
                left_sr <= left_sr << 1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a frame-level model predicts each output from the
// cycle position within the frame and the sample pair latched at the end of
// the previous frame; received slots are also reassembled on rising BCLK.
module tb_i2s_tx;
    import audio_pkg::*;

    localparam int W     = 24;
    localparam int SLOT  = 32;
    localparam int DIV   = 4;
    localparam int FRAME = 2 * SLOT * DIV;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                mute = 1'b0;
    logic signed [W-1:0] left_in = '0;
    logic signed [W-1:0] right_in = '0;
    logic                bclk;
    logic                lrclk;
    logic                sdata;
    logic                frame_strobe;

    i2s_tx #(
        .WIDTH    (W),
        .SLOT     (SLOT),
        .BCLK_DIV (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .left_in      (left_in),
        .right_in     (right_in),
        .mute         (mute),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_strobe (frame_strobe)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    string       phase = "init";
    logic [W-1:0] cur_l = '0;
    logic [W-1:0] cur_r = '0;
    logic [W-1:0] pend_l = '0;
    logic [W-1:0] pend_r = '0;
    logic [31:0]  word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s/%s cyc=%0d observed=%0h expected=%0h", phase, tag, cyc, obs, exp);
    endtask

    // Expected sdata at frame cycle k from the I2S slot rules.
    function automatic logic exp_sdata(input int k);
        int b;
        int pos;
        logic [W-1:0] s;
        b   = k / DIV;
        pos = b % SLOT;
        s   = (b >= SLOT) ? cur_r : cur_l;
        if (pos >= 1 && pos <= W) return s[W-pos];
        return 1'b0;
    endfunction

    // One clk: capture latch data, advance the model, then check outputs.
    task automatic cycle();
        int k;
        int pos;
        logic [W-1:0] s;
        if (rst && (cyc % FRAME == FRAME - 1)) begin
            pend_l = mute ? '0 : left_in;
            pend_r = mute ? '0 : right_in;
        end
        @(posedge clk);
        if (!rst) begin
            cyc   = 0;
            cur_l = '0;
            cur_r = '0;
        end else begin
            cyc++;
            if (cyc % FRAME == 0) begin
                cur_l = pend_l;
                cur_r = pend_r;
            end
        end
        #1;
        k = cyc % FRAME;
        check("bclk", 32'(bclk), 32'((k % DIV) >= DIV / 2));
        check("lrclk", 32'(lrclk), 32'((k / DIV) >= SLOT));
        check("sdata", 32'(sdata), 32'(exp_sdata(k)));
        check("frame_strobe", 32'(frame_strobe), 32'(k == FRAME - 1));
        // Codec view: sample sdata in the cycle where BCLK has just risen.
        if (k % DIV == DIV / 2) begin
            pos = (k / DIV) % SLOT;
            if (pos == 0) word = '0;
            word = {word[30:0], sdata};
            if (pos == SLOT - 1) begin
                s = ((k / DIV) >= SLOT) ? cur_r : cur_l;
                check(((k / DIV) >= SLOT) ? "word_r" : "word_l", word, 32'(s) << (SLOT - 1 - W));
            end
        end
    endtask

    initial begin
        // Reset held for five cycles.
        phase = "reset";
        rst = 1'b0;
        repeat (5) cycle();
        rst = 1'b1;

        // Constant extreme-valued inputs; the first frame must be zeros.
        phase = "hold";
        left_in  = 24'h800001;
        right_in = 24'h7FFFFF;
        repeat (3 * FRAME) cycle();

        // Inputs churn every cycle except the strobe cycle.
        phase = "toggle";
        repeat (2 * FRAME) begin
            if (cyc % FRAME == FRAME - 1) begin
                left_in  = 24'hA5A5A5;
                right_in = 24'h5A5A5A;
            end else begin
                left_in  = W'($urandom);
                right_in = W'($urandom);
            end
            cycle();
        end

        // Mute at latch, then mute rising mid-frame.
        phase = "mute_latch";
        repeat (FRAME) begin
            mute     = 1'b1;
            left_in  = 24'h123456;
            right_in = W'($urandom);
            cycle();
        end
        phase = "unmute";
        repeat (FRAME) begin
            mute     = 1'b0;
            left_in  = 24'h654321;
            right_in = 24'h0ABCDE;
            cycle();
        end
        phase = "mute_mid";
        repeat (FRAME) begin
            mute = (cyc % FRAME >= 100);
            cycle();
        end
        phase = "mute_off";
        repeat (FRAME) begin
            mute     = 1'b0;
            left_in  = W'($urandom);
            right_in = W'($urandom);
            cycle();
        end

        // Random data with random mute.
        phase = "random";
        repeat (2 * FRAME) begin
            left_in  = W'($urandom);
            right_in = W'($urandom);
            mute     = ($urandom_range(0, 3) == 0);
            cycle();
        end

        // One-cycle reset at bit_cnt 40 aborts the frame.
        phase = "mid_reset";
        mute = 1'b0;
        for (int i = 0; i < FRAME && (cyc % FRAME != 40 * DIV); i++) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        phase = "after_reset";
        repeat (2 * FRAME + 8) begin
            left_in  = W'($urandom);
            right_in = W'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
